qcu_bus_fabric: RTL and testbench
=================================

QCU_BUS_FABRIC -- requirements
Module: qcu_bus_fabric

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4, number of peripheral slots (1..16).
REQ-002 SHALL have parameter BASE_PAGE, default 16'h4000; slot i decodes at bus_addr[31:16] == BASE_PAGE + i.
REQ-003 SHALL have parameter STATUS_PAGE, default 16'h4FFF, the fabric status window.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, the maximum slave wait before an error response.
REQ-005 SHALL have ports: clk in 1 system clock; rst in 1 asynchronous active-high reset.
REQ-006 SHALL have master-side ports: bus_cs in 1; bus_we in 1; bus_addr in 32; bus_wdata in 32; bus_rdata out 32; bus_ready out 1; bus_err out 1.
REQ-007 SHALL have slave-side ports: s_cs out NUM_SLAVES; s_we out 1; s_addr out 16; s_wdata out 32; s_rdata in NUM_SLAVES x 32; s_ready in NUM_SLAVES.

Function
REQ-008 SHALL implement FSM states IDLE, ACCESS, RESP and HOLD.
REQ-009 In IDLE with bus_cs=1, SHALL latch bus_addr, bus_we and bus_wdata, then decode from the latched address.
REQ-010 Slot hit SHALL transition to ACCESS; a STATUS_PAGE hit SHALL transition to RESP with status data; any other page SHALL transition to RESP with error.
REQ-011 In ACCESS, SHALL drive only s_cs[hit]=1, with s_we, s_addr (latched addr[15:0]) and s_wdata from the latches; all other s_cs bits SHALL be 0.
REQ-012 In ACCESS, s_ready[hit]=1 SHALL register s_rdata[hit] (reads) and transition to RESP; s_ready of non-selected slots SHALL be ignored.
REQ-013 Wait counter: cleared on ACCESS entry, incremented each ACCESS cycle; reaching TIMEOUT_CYCLES without ready SHALL transition to RESP with error.
REQ-014 RESP SHALL last exactly one cycle with bus_ready=1, and bus_err=1 only on error.
REQ-015 Minimum latency for a slot access: bus_cs sampled at edge N, s_cs high during cycle N+1, bus_ready high at cycle N+2 if s_ready is returned in the first ACCESS cycle.
REQ-016 On error, bus_rdata SHALL be 32'hDEAD_BEEF, slave writes SHALL be dropped, err_count SHALL increment (16-bit, saturating at 16'hFFFF), and last_err_addr SHALL latch the full address.
REQ-017 Status reads SHALL return: offset 0x0 -> {16'h0, err_count}; 0x4 -> last_err_addr; 0x8 -> {16'h0, NUM_SLAVES[7:0], TIMEOUT_CYCLES[7:0]}; any other offset -> 0.
REQ-018 A status write to offset 0x0 SHALL clear err_count and last_err_addr; other status writes SHALL be ignored without error.
REQ-019 If the clear and an error increment coincide, the clear SHALL take priority.
REQ-020 After RESP, SHALL enter HOLD and return to IDLE only when bus_cs=0, so a held cs is never re-issued.
REQ-021 bus_rdata SHALL be registered and SHALL hold its value outside RESP; for writes it SHALL be 0.
REQ-022 Changes on master inputs outside IDLE SHALL NOT affect the transaction in progress.

Reset
REQ-023 rst SHALL asynchronously force state IDLE, s_cs=0, bus_ready=0, bus_err=0, bus_rdata=0, err_count=0, last_err_addr=0 and the wait counter to 0.
REQ-024 Reset asserted mid-ACCESS SHALL abort the transaction with no response pulse after release.
REQ-025 The first transaction after reset release SHALL be sampled on the first clk edge with rst=0.

Structure
REQ-026 The FSM state enum, STATUS_PAGE default, status offsets and the 32'hDEAD_BEEF error pattern SHALL reside in shared package qcu_bus_pkg.
REQ-027 The address decoder SHALL be a combinational sub-module, qcu_addr_decode (latched addr -> one-hot hit, status_hit, miss).
REQ-028 The existing qubit_grid SHALL attach as slot 0 without modification.

Verification
REQ-029 Read of 0x4000_0004 with s_ready[0] asserted on the first ACCESS cycle -> bus_ready 2 cycles after cs, bus_rdata = slave value, bus_err=0.
REQ-030 Write of 0x4002_0008 / 32'h1234_5678 with ready delayed 5 cycles -> s_cs=3'b100 for 6 cycles, s_wdata=32'h1234_5678, single bus_ready pulse.
REQ-031 Read of 0x5000_0000 -> bus_err=1, bus_rdata=32'hDEAD_BEEF, status offset 0x0 reads 1, offset 0x4 reads 32'h5000_0000.
REQ-032 Slot 1 never asserts ready -> error response after 16 ACCESS cycles, err_count increments.
REQ-033 bus_cs held high for 10 cycles after bus_ready -> exactly one transaction issued.
REQ-034 rst pulsed during ACCESS -> all outputs 0, state IDLE, err_count=0, no bus_ready pulse.

Source files
------------

// File: rtl/qcu_bus_pkg.sv
// Shared definitions for the QCU peripheral bus fabric: FSM encoding,
// status window layout and the error response pattern.
package qcu_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP,
        ST_HOLD
    } state_t;

    localparam logic [15:0] STATUS_PAGE_DEFAULT = 16'h4FFF;

    localparam logic [15:0] STAT_OFF_ERR_COUNT = 16'h0000;
    localparam logic [15:0] STAT_OFF_LAST_ERR  = 16'h0004;
    localparam logic [15:0] STAT_OFF_CONFIG    = 16'h0008;

    localparam logic [31:0] ERR_PATTERN = 32'hDEAD_BEEF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/qcu_addr_decode.sv
// Page decoder: maps the upper address half onto a one-hot slot hit,
// the fabric status window, or a miss.
module qcu_addr_decode
    import qcu_bus_pkg::*;
#(
    parameter int          NUM_SLAVES  = 4,
    parameter logic [15:0] BASE_PAGE   = 16'h4000,
    parameter logic [15:0] STATUS_PAGE = STATUS_PAGE_DEFAULT
) (
    input  logic [15:0]            page,
    output logic [NUM_SLAVES-1:0]  hit,
    output logic                   status_hit,
    output logic                   miss
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slot
            localparam logic [15:0] SLOT_PAGE = BASE_PAGE + 16'(gi);
            assign hit[gi] = (page == SLOT_PAGE);
        end
    endgenerate

    // A slot page overlapping the status page wins, so hit stays exclusive.
    assign status_hit = (page == STATUS_PAGE) && !(|hit);
    assign miss       = !(|hit) && !status_hit;

endmodule

// File: rtl/qcu_bus_fabric.sv
// Single-master peripheral fabric: decodes a master request onto one of
// NUM_SLAVES slots or the status window, with timeout and error tracking.
module qcu_bus_fabric
    import qcu_bus_pkg::*;
#(
    parameter int          NUM_SLAVES     = 4,
    parameter logic [15:0] BASE_PAGE      = 16'h4000,
    parameter logic [15:0] STATUS_PAGE    = STATUS_PAGE_DEFAULT,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        bus_cs,
    input  logic                        bus_we,
    input  logic [31:0]                 bus_addr,
    input  logic [31:0]                 bus_wdata,
    output logic [31:0]                 bus_rdata,
    output logic                        bus_ready,
    output logic                        bus_err,
    output logic [NUM_SLAVES-1:0]       s_cs,
    output logic                        s_we,
    output logic [15:0]                 s_addr,
    output logic [31:0]                 s_wdata,
    input  logic [NUM_SLAVES-1:0][31:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]       s_ready
);

    localparam int              WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      CFG_SLOTS = 8'(NUM_SLAVES);
    localparam logic [7:0]      CFG_TMO   = 8'(TIMEOUT_CYCLES);

    state_t              state_reg;
    logic [31:0]         addr_reg;
    logic                we_reg;
    logic [31:0]         wdata_reg;
    logic [WAIT_W-1:0]   wait_cnt_reg;
    logic [15:0]         err_count_reg;
    logic [31:0]         last_err_addr_reg;

    logic [31:0]           dec_addr;
    logic [NUM_SLAVES-1:0] hit;
    logic                  status_hit;
    logic                  miss;
    logic                  sel_ready;
    logic [31:0]           sel_rdata;
    logic [31:0]           status_rdata;
    logic                  start;
    logic                  timeout;
    logic                  err_evt;
    logic                  clear_evt;

    // In IDLE the live address is decoded so the transition happens on the
    // sampling edge; afterwards the latched copy drives the decoder.
    assign dec_addr = (state_reg == ST_IDLE) ? bus_addr : addr_reg;

    qcu_addr_decode #(
        .NUM_SLAVES  (NUM_SLAVES),
        .BASE_PAGE   (BASE_PAGE),
        .STATUS_PAGE (STATUS_PAGE)
    ) u_decode (
        .page       (dec_addr[31:16]),
        .hit        (hit),
        .status_hit (status_hit),
        .miss       (miss)
    );

    assign s_cs    = (state_reg == ST_ACCESS) ? hit : '0;
    assign s_we    = (state_reg == ST_ACCESS) && we_reg;
    assign s_addr  = addr_reg[15:0];
    assign s_wdata = wdata_reg;

    assign sel_ready = |(s_ready & hit);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (hit[i]) begin
                sel_rdata = sel_rdata | s_rdata[i];
            end
        end
    end

    always_comb begin
        case (dec_addr[15:0])
            STAT_OFF_ERR_COUNT: status_rdata = {16'h0000, err_count_reg};
            STAT_OFF_LAST_ERR:  status_rdata = last_err_addr_reg;
            STAT_OFF_CONFIG:    status_rdata = {16'h0000, CFG_SLOTS, CFG_TMO};
            default:            status_rdata = 32'h0000_0000;
        endcase
    end

    assign start     = (state_reg == ST_IDLE) && bus_cs;
    assign timeout   = (state_reg == ST_ACCESS) && !sel_ready && (wait_cnt_reg == WAIT_LAST);
    assign err_evt   = (start && miss) || timeout;
    assign clear_evt = start && status_hit && bus_we && (dec_addr[15:0] == STAT_OFF_ERR_COUNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            addr_reg          <= '0;
            we_reg            <= 1'b0;
            wdata_reg         <= '0;
            wait_cnt_reg      <= '0;
            err_count_reg     <= '0;
            last_err_addr_reg <= '0;
            bus_rdata         <= '0;
            bus_ready         <= 1'b0;
            bus_err           <= 1'b0;
        end else begin
            bus_ready <= 1'b0;
            bus_err   <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus_cs) begin
                        addr_reg  <= bus_addr;
                        we_reg    <= bus_we;
                        wdata_reg <= bus_wdata;
                        if (|hit) begin
                            state_reg    <= ST_ACCESS;
                            wait_cnt_reg <= '0;
                        end else begin
                            state_reg <= ST_RESP;
                            bus_ready <= 1'b1;
                            bus_err   <= miss;
                            bus_rdata <= miss ? ERR_PATTERN : (bus_we ? 32'h0 : status_rdata);
                        end
                    end
                end
                ST_ACCESS: begin
                    if (sel_ready) begin
                        state_reg <= ST_RESP;
                        bus_ready <= 1'b1;
                        bus_rdata <= we_reg ? 32'h0 : sel_rdata;
                    end else if (timeout) begin
                        state_reg <= ST_RESP;
                        bus_ready <= 1'b1;
                        bus_err   <= 1'b1;
                        bus_rdata <= ERR_PATTERN;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                ST_RESP: begin
                    state_reg <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!bus_cs) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase

            // Clearing the error log outranks a simultaneous error.
            if (clear_evt) begin
                err_count_reg     <= '0;
                last_err_addr_reg <= '0;
            end else if (err_evt) begin
                err_count_reg     <= sat_inc16(err_count_reg);
                last_err_addr_reg <= dec_addr;
            end
        end
    end

endmodule

// File: tb/tb_qcu_bus_fabric.sv
// Randomized and directed bench for qcu_bus_fabric against a transaction-level
// reference model (address classification, latency and error log).
module tb_qcu_bus_fabric;

    localparam int NS = 4;
    localparam int TO = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                bus_cs;
    logic                bus_we;
    logic [31:0]         bus_addr;
    logic [31:0]         bus_wdata;
    logic [31:0]         bus_rdata;
    logic                bus_ready;
    logic                bus_err;
    logic [NS-1:0]       s_cs;
    logic                s_we;
    logic [15:0]         s_addr;
    logic [31:0]         s_wdata;
    logic [NS-1:0][31:0] s_rdata;
    logic [NS-1:0]       s_ready;

    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    logic [15:0] m_err_count;
    logic [31:0] m_last_err;

    always #5 clk = ~clk;

    qcu_bus_fabric #(
        .NUM_SLAVES     (NS),
        .BASE_PAGE      (16'h4000),
        .STATUS_PAGE    (16'h4FFF),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_cs    (bus_cs),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .bus_err   (bus_err),
        .s_cs      (s_cs),
        .s_we      (s_we),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_rdata   (s_rdata),
        .s_ready   (s_ready)
    );

    // Reference model: classify the address and derive latency, response and error log.
    task automatic model_txn(input logic [31:0] addr, input logic we, input logic [31:0] slave_val,
                             input int lat, output int exp_rdy, output int exp_acc,
                             output logic exp_err, output logic [31:0] exp_rdata);
        int          pg;
        logic [15:0] off;
        logic        err;
        pg  = int'(addr[31:16]);
        off = addr[15:0];
        err = 1'b0;
        exp_acc   = 0;
        exp_rdy   = 1;
        exp_rdata = 32'h0;
        if (pg >= 'h4000 && pg < 'h4000 + NS) begin
            if (lat >= 0 && lat < TO) begin
                exp_acc   = lat + 1;
                exp_rdy   = lat + 2;
                exp_rdata = we ? 32'h0 : slave_val;
            end else begin
                exp_acc = TO;
                exp_rdy = TO + 1;
                err     = 1'b1;
            end
        end else if (pg == 'h4FFF) begin
            if (we) begin
                if (off == 16'h0) begin
                    m_err_count = 16'h0;
                    m_last_err  = 32'h0;
                end
            end else if (off == 16'h0) begin
                exp_rdata = {16'h0, m_err_count};
            end else if (off == 16'h4) begin
                exp_rdata = m_last_err;
            end else if (off == 16'h8) begin
                exp_rdata = {16'h0, 8'(NS), 8'(TO)};
            end
        end else begin
            err = 1'b1;
        end
        if (err) begin
            exp_rdata   = 32'hDEAD_BEEF;
            m_err_count = (m_err_count == 16'hFFFF) ? m_err_count : m_err_count + 16'd1;
            m_last_err  = addr;
        end
        exp_err = err;
    endtask

    // Drives one master transaction and emulates the slaves; lat<0 means the target never answers.
    task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input int lat, input int hold,
                           output int rdy_cyc, output int pulses, output logic err_o,
                           output logic [31:0] rdata_o, output logic [31:0] slave_val,
                           output int acc_cyc, output int bad_cyc, output logic [31:0] rdata_end);
        int          pg;
        int          tgt;
        logic [NS-1:0] exp_cs;
        pg  = int'(addr[31:16]);
        tgt = (pg >= 'h4000 && pg < 'h4000 + NS) ? pg - 'h4000 : -1;
        exp_cs = (tgt >= 0) ? NS'(1 << tgt) : '0;
        @(negedge clk);
        for (int i = 0; i < NS; i++) s_rdata[i] = $urandom;
        slave_val = (tgt >= 0) ? s_rdata[tgt] : 32'h0;
        bus_cs = 1'b1; bus_addr = addr; bus_we = we; bus_wdata = wdata;
        s_ready = NS'($urandom) & ~exp_cs;
        rdy_cyc = -1; pulses = 0; acc_cyc = 0; bad_cyc = 0; err_o = 1'b0; rdata_o = 32'h0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (bus_ready) begin
                pulses++;
                if (rdy_cyc < 0) begin
                    rdy_cyc = k; err_o = bus_err; rdata_o = bus_rdata;
                end
            end
            if (s_cs != '0) begin
                acc_cyc++;
                if (s_cs !== exp_cs || s_we !== we || s_addr !== addr[15:0] ||
                    s_wdata !== wdata || rdy_cyc >= 0) bad_cyc++;
            end
            s_ready = NS'($urandom) & ~exp_cs;
            if (s_cs != '0 && lat >= 0 && acc_cyc >= lat + 1) s_ready = s_ready | exp_cs;
            if (k == 1) begin
                bus_addr = $urandom; bus_we = 1'($urandom); bus_wdata = $urandom;
                if (hold == 0) bus_cs = 1'b0;
            end
            if (rdy_cyc >= 0 && k >= rdy_cyc + hold) bus_cs = 1'b0;
            if (rdy_cyc >= 0 && k >= rdy_cyc + hold + 3) break;
        end
        rdata_end = bus_rdata;
        bus_cs = 1'b0;
        s_ready = '0;
        txn_no++;
        $display("txn %0d addr=%h we=%0d lat=%0d ready_at=%0d err=%0d rdata=%h",
                 txn_no, addr, we, lat, rdy_cyc, err_o, rdata_o);
    endtask

    task automatic test_reset();
        rst = 1'b1; bus_cs = 1'b0; bus_we = 1'b0; bus_addr = 32'h0; bus_wdata = 32'h0;
        s_ready = '0; s_rdata = '0;
        m_err_count = 16'h0; m_last_err = 32'h0;
        repeat (3) @(negedge clk);
        checks++; if ({bus_ready, bus_err, bus_rdata, s_cs, s_we} !== '0) begin
            errors++; $display("FAIL reset_outputs got rdy=%0d err=%0d rdata=%h s_cs=%b want all zero",
                               bus_ready, bus_err, bus_rdata, s_cs);
        end
        rst = 1'b0; bus_cs = 1'b1; bus_addr = 32'h4FFF_0008; bus_we = 1'b0;
        @(negedge clk);
        bus_cs = 1'b0;
        checks++; if (bus_ready !== 1'b1 || bus_rdata !== {16'h0, 8'(NS), 8'(TO)}) begin
            errors++; $display("FAIL first_after_reset got rdy=%0d rdata=%h want rdy=1 rdata=%h",
                               bus_ready, bus_rdata, {16'h0, 8'(NS), 8'(TO)});
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_slot_read();
        int rc, pc, ac, bc, erc, eac; logic er, eer; logic [31:0] rd, sv, re, erd;
        run_txn(32'h4000_0004, 1'b0, 32'h0, 0, 0, rc, pc, er, rd, sv, ac, bc, re);
        model_txn(32'h4000_0004, 1'b0, sv, 0, erc, eac, eer, erd);
        checks++; if (rc !== 2) begin errors++; $display("FAIL read_latency got %0d want 2", rc); end
        checks++; if (rd !== erd || er !== 1'b0) begin
            errors++; $display("FAIL read_data got %h err=%0d want %h err=0", rd, er, erd);
        end
        checks++; if (bc !== 0 || ac !== 1) begin
            errors++; $display("FAIL read_select got bad=%0d acc=%0d want 0 and 1", bc, ac);
        end
    endtask

    task automatic test_slot_write_delayed();
        int rc, pc, ac, bc, erc, eac; logic er, eer; logic [31:0] rd, sv, re, erd;
        run_txn(32'h4002_0008, 1'b1, 32'h1234_5678, 5, 0, rc, pc, er, rd, sv, ac, bc, re);
        model_txn(32'h4002_0008, 1'b1, sv, 5, erc, eac, eer, erd);
        checks++; if (ac !== 6 || bc !== 0) begin
            errors++; $display("FAIL write_cs got acc=%0d bad=%0d want 6 and 0", ac, bc);
        end
        checks++; if (pc !== 1 || rc !== erc) begin
            errors++; $display("FAIL write_ready got pulses=%0d at=%0d want 1 at %0d", pc, rc, erc);
        end
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin
            errors++; $display("FAIL write_resp got %h err=%0d want 0 err=0", rd, er);
        end
    endtask

    task automatic test_miss_and_status();
        int rc, pc, ac, bc, erc, eac; logic er, eer; logic [31:0] rd, sv, re, erd;
        logic [31:0] offs [4];
        offs = '{32'h4FFF_0000, 32'h4FFF_0004, 32'h4FFF_0008, 32'h4FFF_000C};
        run_txn(32'h5000_0000, 1'b0, 32'h0, 0, 0, rc, pc, er, rd, sv, ac, bc, re);
        model_txn(32'h5000_0000, 1'b0, sv, 0, erc, eac, eer, erd);
        checks++; if (er !== 1'b1 || rd !== 32'hDEAD_BEEF || rc !== 1) begin
            errors++; $display("FAIL miss_resp got err=%0d rdata=%h at=%0d want err=1 rdata=deadbeef at 1",
                               er, rd, rc);
        end
        checks++; if (re !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL miss_hold got %h want deadbeef", re);
        end
        foreach (offs[i]) begin
            run_txn(offs[i], 1'b0, 32'h0, 0, 0, rc, pc, er, rd, sv, ac, bc, re);
            model_txn(offs[i], 1'b0, sv, 0, erc, eac, eer, erd);
            checks++; if (rd !== erd || er !== 1'b0) begin
                errors++; $display("FAIL status_read %h got %h err=%0d want %h err=0", offs[i], rd, er, erd);
            end
        end
    endtask

    task automatic test_timeout();
        int rc, pc, ac, bc, erc, eac; logic er, eer; logic [31:0] rd, sv, re, erd;
        run_txn(32'h4001_0020, 1'b1, 32'hCAFE_0001, -1, 0, rc, pc, er, rd, sv, ac, bc, re);
        model_txn(32'h4001_0020, 1'b1, sv, -1, erc, eac, eer, erd);
        checks++; if (ac !== TO || rc !== TO + 1) begin
            errors++; $display("FAIL timeout_len got acc=%0d at=%0d want %0d at %0d", ac, rc, TO, TO + 1);
        end
        checks++; if (er !== 1'b1 || rd !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL timeout_resp got err=%0d rdata=%h want 1 deadbeef", er, rd);
        end
        run_txn(32'h4FFF_0000, 1'b0, 32'h0, 0, 0, rc, pc, er, rd, sv, ac, bc, re);
        model_txn(32'h4FFF_0000, 1'b0, sv, 0, erc, eac, eer, erd);
        checks++; if (rd !== erd) begin
            errors++; $display("FAIL timeout_count got %h want %h", rd, erd);
        end
        run_txn(32'h4002_0000, 1'b0, 32'h0, TO - 1, 0, rc, pc, er, rd, sv, ac, bc, re);
        model_txn(32'h4002_0000, 1'b0, sv, TO - 1, erc, eac, eer, erd);
        checks++; if (er !== 1'b0 || rd !== erd || rc !== erc) begin
            errors++; $display("FAIL last_cycle_ready got err=%0d rdata=%h at=%0d want 0 %h at %0d",
                               er, rd, rc, erd, erc);
        end
    endtask

    task automatic test_held_cs();
        int rc, pc, ac, bc, erc, eac; logic er, eer; logic [31:0] rd, sv, re, erd;
        run_txn(32'h4003_0010, 1'b0, 32'h0, 1, 10, rc, pc, er, rd, sv, ac, bc, re);
        model_txn(32'h4003_0010, 1'b0, sv, 1, erc, eac, eer, erd);
        checks++; if (pc !== 1 || ac !== eac || bc !== 0) begin
            errors++; $display("FAIL held_cs got pulses=%0d acc=%0d bad=%0d want 1 %0d 0", pc, ac, bc, eac);
        end
        checks++; if (re !== erd) begin
            errors++; $display("FAIL held_rdata got %h want %h", re, erd);
        end
    endtask

    task automatic test_status_clear();
        int rc, pc, ac, bc, erc, eac; logic er, eer; logic [31:0] rd, sv, re, erd;
        logic [31:0] seq_addr [5];
        logic        seq_we   [5];
        seq_addr = '{32'h6000_1234, 32'h4FFF_0004, 32'h4FFF_0000, 32'h4FFF_0000, 32'h4FFF_0004};
        seq_we   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        foreach (seq_addr[i]) begin
            run_txn(seq_addr[i], seq_we[i], $urandom, 0, 0, rc, pc, er, rd, sv, ac, bc, re);
            model_txn(seq_addr[i], seq_we[i], sv, 0, erc, eac, eer, erd);
            checks++; if (rd !== erd || er !== eer || pc !== 1) begin
                errors++; $display("FAIL status_seq %0d got %h err=%0d pulses=%0d want %h err=%0d pulses=1",
                                   i, rd, er, pc, erd, eer);
            end
        end
    endtask

    task automatic test_random();
        int rc, pc, ac, bc, erc, eac, lat, hold, r; logic er, eer, we; logic [31:0] rd, sv, re, erd, addr;
        logic [15:0] offs [4];
        offs = '{16'h0, 16'h4, 16'h8, 16'hC};
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            we = 1'($urandom);
            hold = $urandom_range(0, 3);
            lat = $urandom_range(0, 6);
            if (r < 5) begin
                addr = {16'h4000 + 16'($urandom_range(0, NS - 1)), 16'($urandom)};
                case ($urandom_range(0, 7))
                    0: lat = -1;
                    1: lat = TO - 1;
                    default: ;
                endcase
            end else if (r < 8) begin
                addr = {16'h4FFF, offs[$urandom_range(0, 3)]};
                if (addr[15:0] == 16'h0 && $urandom_range(0, 2) != 0) we = 1'b0;
            end else begin
                addr = $urandom;
                if (addr[31:16] == 16'h4FFF || (addr[31:16] >= 16'h4000 && addr[31:16] < 16'h4004))
                    addr[31:16] = 16'h7000;
            end
            run_txn(addr, we, $urandom, lat, hold, rc, pc, er, rd, sv, ac, bc, re);
            model_txn(addr, we, sv, lat, erc, eac, eer, erd);
            checks++; if (rc !== erc || pc !== 1) begin
                errors++; $display("FAIL rnd_ready %h got at=%0d pulses=%0d want at=%0d pulses=1",
                                   addr, rc, pc, erc);
            end
            checks++; if (rd !== erd || er !== eer) begin
                errors++; $display("FAIL rnd_resp %h got %h err=%0d want %h err=%0d", addr, rd, er, erd, eer);
            end
            checks++; if (ac !== eac || bc !== 0 || re !== erd) begin
                errors++; $display("FAIL rnd_slave %h got acc=%0d bad=%0d hold=%h want acc=%0d bad=0 hold=%h",
                                   addr, ac, bc, re, eac, erd);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        int rc, pc, ac, bc, erc, eac, cs_seen; logic er, eer; logic [31:0] rd, sv, re, erd;
        run_txn(32'h6000_0000, 1'b0, 32'h0, 0, 0, rc, pc, er, rd, sv, ac, bc, re);
        model_txn(32'h6000_0000, 1'b0, sv, 0, erc, eac, eer, erd);
        @(negedge clk);
        bus_cs = 1'b1; bus_addr = 32'h4001_0010; bus_we = 1'b0; s_ready = '0;
        @(negedge clk);
        bus_cs = 1'b0;
        checks++; if (s_cs !== 4'b0010) begin
            errors++; $display("FAIL mid_access_cs got %b want 0010", s_cs);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if ({bus_ready, bus_err, bus_rdata, s_cs, s_we} !== '0) begin
            errors++; $display("FAIL async_reset got rdy=%0d err=%0d rdata=%h s_cs=%b want all zero",
                               bus_ready, bus_err, bus_rdata, s_cs);
        end
        @(negedge clk);
        rst = 1'b0;
        m_err_count = 16'h0; m_last_err = 32'h0;
        pc = 0; cs_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus_ready) pc++;
            if (s_cs != '0) cs_seen++;
        end
        checks++; if (pc !== 0 || cs_seen !== 0) begin
            errors++; $display("FAIL abort_after_reset got pulses=%0d cs_cycles=%0d want 0 0", pc, cs_seen);
        end
        run_txn(32'h4FFF_0000, 1'b0, 32'h0, 0, 0, rc, pc, er, rd, sv, ac, bc, re);
        model_txn(32'h4FFF_0000, 1'b0, sv, 0, erc, eac, eer, erd);
        checks++; if (rd !== erd) begin
            errors++; $display("FAIL reset_err_count got %h want %h", rd, erd);
        end
    endtask

    initial begin
        test_reset();
        test_slot_read();
        test_slot_write_delayed();
        test_miss_and_status();
        test_timeout();
        test_held_cs();
        test_status_clear();
        test_random();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
